mem_arbiter: RTL and testbench

Two-port arbiter that shares the single byte-addressable data memory between the instruction-fetch port and the load/store port of the core. It accepts one request at a time through valid/ready handshakes. It registers the request and drives the memory's address, write-data, width and write-enable inputs for exactly one access cycle. It then returns the read value and a fault flag to the granted requester, holding them until that requester accepts the response.

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Shares one byte-addressable data memory between the fetch port and the load/store port.
// Optional round-robin tie-breaking is built when MEM_ARB_RR_EN is defined.
module mem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_req_valid,
    output logic            i_req_ready,
    input  logic [XLEN-1:0] i_req_addr,
    output logic            i_resp_valid,
    input  logic            i_resp_ready,
    output logic [XLEN-1:0] i_resp_data,
    output logic            i_resp_fault,
    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic [XLEN-1:0] d_req_addr,
    input  logic [XLEN-1:0] d_req_wdata,
    input  logic [2:0]      d_req_width,
    input  logic            d_req_write,
    output logic            d_resp_valid,
    input  logic            d_resp_ready,
    output logic [XLEN-1:0] d_resp_data,
    output logic            d_resp_fault,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [2:0]      mem_width,
    output logic            mem_write_en,
    input  logic [XLEN-1:0] mem_valM,
    input  logic            mem_fault,
    output logic [1:0]      fsm_state
);
    // Handshakes: a request transfers on a rising edge where valid and ready are both high;
    // a response is held stable from its first valid cycle until the edge where ready is high.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state, state_next;
    logic              grant_d, grant_i;
    logic              d_hs, i_hs, hs;
    logic              misalign, resp_accept;
    logic              owner_d;
    logic [XLEN-1:0]   req_addr, req_wdata, resp_data;
    logic [2:0]        req_width;
    logic              req_write, resp_fault;

`ifdef MEM_ARB_RR_EN
    logic last_fetch;
    // A tie goes to the port that did not win the previous handshake.
    assign grant_d = d_req_valid & (~i_req_valid | last_fetch);

    always_ff @(posedge clock) begin
        if (reset)   last_fetch <= 1'b1;
        else if (hs) last_fetch <= i_hs;
    end
`else
    assign grant_d = d_req_valid;
`endif
    assign grant_i = i_req_valid & ~grant_d;

    assign d_hs        = d_req_valid & d_req_ready;
    assign i_hs        = i_req_valid & i_req_ready;
    assign hs          = d_hs | i_hs;
    assign misalign    = ((req_width == 3'b001) && req_addr[0]) ||
                         ((req_width == 3'b010) && (req_addr[1:0] != 2'b00));
    assign resp_accept = owner_d ? d_resp_ready : i_resp_ready;
    assign fsm_state   = state;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (hs) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (resp_accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        i_req_ready  = 1'b0;
        d_req_ready  = 1'b0;
        i_resp_valid = 1'b0;
        d_resp_valid = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_width    = 3'b000;
        mem_write_en = 1'b0;
        case (state)
            IDLE: begin
                d_req_ready = grant_d & ~reset;
                i_req_ready = grant_i & ~reset;
            end
            ACCESS: begin
                mem_addr     = req_addr;
                mem_wdata    = req_wdata;
                mem_width    = req_width;
                mem_write_en = req_write & ~misalign & ~reset;
            end
            RESP: begin
                d_resp_valid = owner_d;
                i_resp_valid = ~owner_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            req_addr   <= '0;
            req_wdata  <= '0;
            req_width  <= 3'b000;
            req_write  <= 1'b0;
            owner_d    <= 1'b0;
            resp_data  <= '0;
            resp_fault <= 1'b0;
        end else begin
            if (d_hs) begin
                req_addr  <= d_req_addr;
                req_wdata <= d_req_wdata;
                req_width <= d_req_width;
                req_write <= d_req_write;
                owner_d   <= 1'b1;
            end else if (i_hs) begin
                req_addr  <= i_req_addr;
                req_wdata <= '0;
                req_width <= 3'b010;
                req_write <= 1'b0;
                owner_d   <= 1'b0;
            end
            // Faults still produce a response; the data register just follows the memory.
            if (state == ACCESS) begin
                resp_data  <= req_write ? '0 : mem_valM;
                resp_fault <= mem_fault | misalign;
            end
        end
    end

    assign i_resp_data  = resp_data;
    assign d_resp_data  = resp_data;
    assign i_resp_fault = resp_fault;
    assign d_resp_fault = resp_fault;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Randomized and directed bench for mem_arbiter with a transaction-level reference model
// and a small behavioural byte memory (faults on address 0 and beyond MEM_SIZE).
module tb_mem_arbiter;
  localparam int XLEN     = 32;
  localparam int MEM_SIZE = 256;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  width;
    logic        write;
  } req_t;

  logic clock = 1'b0;
  logic reset;
  logic i_req_valid, i_req_ready, i_resp_valid, i_resp_ready, i_resp_fault;
  logic [31:0] i_req_addr, i_resp_data;
  logic d_req_valid, d_req_ready, d_req_write, d_resp_valid, d_resp_ready, d_resp_fault;
  logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
  logic [2:0]  d_req_width;
  logic [31:0] mem_addr, mem_wdata, mem_valM;
  logic [2:0]  mem_width;
  logic        mem_write_en, mem_fault;
  logic [1:0]  fsm_state;

  mem_arbiter #(.XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready),
    .i_resp_data(i_resp_data), .i_resp_fault(i_resp_fault),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_width(d_req_width), .d_req_write(d_req_write),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
    .d_resp_data(d_resp_data), .d_resp_fault(d_resp_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_width(mem_width),
    .mem_write_en(mem_write_en), .mem_valM(mem_valM), .mem_fault(mem_fault),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- memory environment ----------------
  logic [7:0] mem_bytes [MEM_SIZE];
  logic       mem_init = 1'b1;

  function automatic int nbytes(input logic [2:0] w);
    case (w)
      3'b000:  return 1;
      3'b001:  return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic oob(input logic [31:0] a, input logic [2:0] w);
    return (a == 32'd0) || (longint'(a) + longint'(nbytes(w)) > longint'(MEM_SIZE));
  endfunction

  always_comb begin
    mem_valM  = '0;
    mem_fault = oob(mem_addr, mem_width);
    if (!mem_fault)
      for (int k = 0; k < nbytes(mem_width); k++)
        mem_valM[8*k +: 8] = mem_bytes[int'(mem_addr) + k];
  end

  always @(posedge clock) begin
    if (mem_init) begin
      for (int k = 0; k < MEM_SIZE; k++) mem_bytes[k] <= 8'h00;
    end else if (mem_write_en && !oob(mem_addr, mem_width)) begin
      for (int k = 0; k < nbytes(mem_width); k++)
        mem_bytes[int'(mem_addr) + k] <= mem_wdata[8*k +: 8];
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [MEM_SIZE];
  req_t d_q[$];
  req_t i_q[$];
  logic [31:0] exp_q[$];
  logic grant_log[$];

  logic busy, phase_resp, owner_d, last_fetch;
  logic d_pres, i_pres, gap_en, resp_random;
  req_t cur;
  logic exp_fault, exp_wen;
  logic [31:0] last_d_data, last_i_data;
  logic last_d_fault, last_i_fault;
  int wen_count;
  int n_checks, n_pass;

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [2:0] w);
    logic [31:0] v;
    v = '0;
    if (!oob(a, w))
      for (int k = 0; k < nbytes(w); k++) v[8*k +: 8] = ref_mem[int'(a) + k];
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_d(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] w,
                        input logic wr);
    req_t r;
    r.addr = a; r.wdata = wd; r.width = w; r.write = wr;
    d_q.push_back(r);
  endtask

  task automatic push_i(input logic [31:0] a);
    req_t r;
    r.addr = a; r.wdata = '0; r.width = 3'b010; r.write = 1'b0;
    i_q.push_back(r);
  endtask

  // One clock cycle: drive after the edge, check at the falling edge, advance the model.
  task automatic step(input logic rst);
    logic g_d, exp_dr, exp_ir, acc, mis, bad;
    logic [1:0] exp_state;
    reset = rst;
    if (!d_pres && d_q.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) d_pres = 1'b1;
    if (!i_pres && i_q.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) i_pres = 1'b1;
    d_req_valid = d_pres;
    d_req_addr  = d_pres ? d_q[0].addr  : $urandom();
    d_req_wdata = d_pres ? d_q[0].wdata : $urandom();
    d_req_width = d_pres ? d_q[0].width : 3'($urandom_range(0, 7));
    d_req_write = d_pres ? d_q[0].write : 1'($urandom_range(0, 1));
    i_req_valid = i_pres;
    i_req_addr  = i_pres ? i_q[0].addr : $urandom();
    d_resp_ready = resp_random ? 1'($urandom_range(0, 1)) : 1'b1;
    i_resp_ready = resp_random ? 1'($urandom_range(0, 1)) : 1'b1;

    @(negedge clock);
`ifdef MEM_ARB_RR_EN
    g_d = d_pres && (!i_pres || last_fetch);
`else
    g_d = d_pres;
`endif
    exp_dr = !rst && !busy && g_d;
    exp_ir = !rst && !busy && i_pres && !g_d;
    exp_state = !busy ? 2'd0 : (phase_resp ? 2'd2 : 2'd1);
    check("d_req_ready", 32'(d_req_ready), 32'(exp_dr));
    check("i_req_ready", 32'(i_req_ready), 32'(exp_ir));
    check("fsm_state", 32'(fsm_state), 32'(exp_state));
    if (mem_write_en) wen_count++;
    if (busy && !phase_resp) begin
      check("mem_addr", mem_addr, cur.addr);
      check("mem_width", 32'(mem_width), 32'(cur.width));
      if (owner_d) check("mem_wdata", mem_wdata, cur.wdata);
      check("mem_write_en", 32'(mem_write_en), 32'(exp_wen && !rst));
    end else begin
      check("mem_idle_we", 32'(mem_write_en), 32'd0);
      check("mem_idle_bus", mem_addr | mem_wdata | 32'(mem_width), 32'd0);
    end
    acc = 1'b0;
    if (busy && phase_resp) begin
      if (owner_d) begin
        check("d_resp_valid", 32'(d_resp_valid), 32'd1);
        check("i_resp_valid_idle", 32'(i_resp_valid), 32'd0);
        check("d_resp_data", d_resp_data, exp_q[0]);
        check("d_resp_fault", 32'(d_resp_fault), 32'(exp_fault));
        acc = d_resp_ready;
      end else begin
        check("i_resp_valid", 32'(i_resp_valid), 32'd1);
        check("d_resp_valid_idle", 32'(d_resp_valid), 32'd0);
        check("i_resp_data", i_resp_data, exp_q[0]);
        check("i_resp_fault", 32'(i_resp_fault), 32'(exp_fault));
        acc = i_resp_ready;
      end
    end else begin
      check("d_resp_valid_off", 32'(d_resp_valid), 32'd0);
      check("i_resp_valid_off", 32'(i_resp_valid), 32'd0);
    end

    @(posedge clock);
    #1;
    mem_init = 1'b0;
    if (rst) begin
      busy = 1'b0;
      last_fetch = 1'b1;
      exp_q.delete();
    end else if (exp_dr || exp_ir) begin
      cur = exp_dr ? d_q.pop_front() : i_q.pop_front();
      if (exp_dr) d_pres = 1'b0; else i_pres = 1'b0;
      owner_d = exp_dr;
      last_fetch = exp_ir;
      grant_log.push_back(exp_dr);
      mis = (cur.addr % nbytes(cur.width)) != 0;
      bad = oob(cur.addr, cur.width);
      exp_fault = mis | bad;
      exp_wen = cur.write && !mis;
      exp_q.push_back(cur.write ? 32'd0 : ref_read(cur.addr, cur.width));
      busy = 1'b1;
      phase_resp = 1'b0;
    end else if (busy && !phase_resp) begin
      // The store lands in memory at the end of the access cycle.
      if (exp_wen && !oob(cur.addr, cur.width))
        for (int k = 0; k < nbytes(cur.width); k++)
          ref_mem[int'(cur.addr) + k] = cur.wdata[8*k +: 8];
      phase_resp = 1'b1;
    end else if (acc) begin
      if (owner_d) begin last_d_data = exp_q[0]; last_d_fault = exp_fault; end
      else         begin last_i_data = exp_q[0]; last_i_fault = exp_fault; end
      void'(exp_q.pop_front());
      busy = 1'b0;
    end
  endtask

  task automatic drain(input int limit);
    int cyc;
    cyc = 0;
    while ((d_q.size() > 0 || i_q.size() > 0 || busy || d_pres || i_pres) && cyc < limit) begin
      step(1'b0);
      cyc++;
    end
    if (cyc >= limit) check("drain_timeout", 32'(cyc), 32'(limit - 1));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int wen_before, cyc;
    n_checks = 0; n_pass = 0; wen_count = 0;
    busy = 1'b0; phase_resp = 1'b0; owner_d = 1'b0; last_fetch = 1'b1;
    d_pres = 1'b0; i_pres = 1'b0; gap_en = 1'b0; resp_random = 1'b0;
    cur = '0; exp_fault = 1'b0; exp_wen = 1'b0;
    last_d_data = '0; last_i_data = '0; last_d_fault = 1'b0; last_i_fault = 1'b0;
    for (int k = 0; k < MEM_SIZE; k++) ref_mem[k] = 8'h00;
    reset = 1'b1;
    d_req_valid = 1'b0; i_req_valid = 1'b0; d_resp_ready = 1'b0; i_resp_ready = 1'b0;
    d_req_addr = '0; d_req_wdata = '0; d_req_width = '0; d_req_write = 1'b0; i_req_addr = '0;

    // Reset values, with a request already waiting at the data port.
    push_d(32'h10, 32'hDEADBEEF, 3'b010, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1);
    check("rst_d_resp_data", d_resp_data, 32'd0);
    check("rst_i_resp_data", i_resp_data, 32'd0);
    check("rst_faults", 32'({d_resp_fault, i_resp_fault}), 32'd0);

    // Store word then fetch it back.
    wen_before = wen_count;
    drain(50);
    check("t1_store_data", last_d_data, 32'd0);
    check("t1_store_fault", 32'(last_d_fault), 32'd0);
    check("t1_store_wen", 32'(wen_count - wen_before), 32'd1);
    push_i(32'h10);
    drain(50);
    check("t1_fetch_data", last_i_data, 32'hDEADBEEF);
    check("t1_fetch_fault", 32'(last_i_fault), 32'd0);

    // Byte store then half load spanning it.
    push_d(32'h21, 32'h000000AB, 3'b000, 1'b1);
    push_d(32'h20, 32'h0, 3'b001, 1'b0);
    drain(50);
    check("t2_load_half", last_d_data, 32'h0000AB00);

    // Misaligned accesses fault and never write.
    wen_before = wen_count;
    push_d(32'h22, 32'h0, 3'b010, 1'b0);
    drain(50);
    check("t3_load_misalign_fault", 32'(last_d_fault), 32'd1);
    push_d(32'h13, 32'h0000FFFF, 3'b001, 1'b1);
    drain(50);
    check("t3_store_misalign_fault", 32'(last_d_fault), 32'd1);
    check("t3_no_write", 32'(wen_count - wen_before), 32'd0);
    push_d(32'h10, 32'h0, 3'b010, 1'b0);
    drain(50);
    check("t3_mem_unchanged", last_d_data, 32'hDEADBEEF);

    // Memory-reported faults still complete.
    push_i(32'h0);
    drain(50);
    check("t4_fetch_fault", 32'(last_i_fault), 32'd1);
    push_d(32'(MEM_SIZE), 32'h0, 3'b010, 1'b0);
    drain(50);
    check("t4_load_oob_fault", 32'(last_d_fault), 32'd1);

    // Both ports contending continuously.
    step(1'b1);
    grant_log.delete();
    for (int k = 0; k < 6; k++) begin
      push_d(32'h10, 32'h0, 3'b010, 1'b0);
      push_i(32'h20);
    end
    drain(200);
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_RR_EN
      check($sformatf("t5_grant%0d", k), 32'(grant_log[k]), 32'((k % 2) == 0));
`else
      check($sformatf("t5_grant%0d", k), 32'(grant_log[k]), 32'd1);
`endif
    end

    // Reset landing on the access cycle of a store cancels it.
    push_d(32'h40, 32'h55667788, 3'b010, 1'b1);
    drain(50);
    push_d(32'h40, 32'h11223344, 3'b010, 1'b1);
    cyc = 0;
    while (!(busy && !phase_resp) && cyc < 10) begin step(1'b0); cyc++; end
    check("t6_reach_access", 32'(busy && !phase_resp), 32'd1);
    step(1'b1);
    check("t6_state_idle", 32'(fsm_state), 32'd0);
    check("t6_resp_valid", 32'({d_resp_valid, i_resp_valid}), 32'd0);
    push_d(32'h40, 32'h0, 3'b010, 1'b0);
    drain(50);
    check("t6_store_dropped", last_d_data, 32'h55667788);

    // Random traffic with gaps and response backpressure.
    gap_en = 1'b1;
    resp_random = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 1) != 0)
        push_d(32'($urandom_range(0, MEM_SIZE + 3)), $urandom(),
               3'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      else
        push_i(32'($urandom_range(0, MEM_SIZE / 4)) * 32'd4);
    end
    drain(8000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
